// File: rtl/usb_bit_pkg.sv
// Shared definitions for the USB bit stuffer / unstuffer pair.
package usb_bit_pkg;

    localparam int USB_STUFF_RUN_LEN = 6;

    typedef enum logic [1:0] {
        COUNT = 2'd0,
        STRIP = 2'd1,
        ERR   = 2'd2
    } unstuff_state_t;

endpackage

// File: rtl/usb_ones_run_counter.sv
// Counts consecutive ones in the bit stream; run_done flags the one that completes a run.
module usb_ones_run_counter
    import usb_bit_pkg::*;
#(
    parameter int RUN_LEN = USB_STUFF_RUN_LEN,
    parameter int CNT_W   = $clog2(RUN_LEN + 1)
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             clear,
    input  logic             en,
    input  logic             in_bit,
    output logic [CNT_W-1:0] cnt,
    output logic             run_done
);

    // Combinational so the owner can act on the completing bit in the same cycle.
    assign run_done = en & in_bit & (cnt == CNT_W'(RUN_LEN - 1));

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            if (!in_bit || run_done) begin
                cnt <= '0;
            end else if (cnt < CNT_W'(RUN_LEN)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_bit_unstuffer.sv
// Receive-side bit unstuffer: drops the zero following every RUN_LEN ones.
// Optional macro USB_UNSTUFF_ERR_EN enables the sticky ERR state and stuff_err pulse.
module usb_bit_unstuffer
    import usb_bit_pkg::*;
#(
    parameter int RUN_LEN = USB_STUFF_RUN_LEN
) (
    input  logic clk,
    input  logic nRST,
    input  logic in_bit,
    input  logic en,
    input  logic clear,
    output logic out_bit,
    output logic out_valid,
    output logic stuff_err
);

    localparam int CNT_W = $clog2(RUN_LEN + 1);

    unstuff_state_t   state_q, state_d;
    logic             bit_d, valid_d, err_d;
    logic             run_done;
    logic [CNT_W-1:0] cnt_unused;

    // Only bits seen in COUNT belong to a run; STRIP/ERR bits never count.
    usb_ones_run_counter #(
        .RUN_LEN (RUN_LEN),
        .CNT_W   (CNT_W)
    ) u_run (
        .clk      (clk),
        .nRST     (nRST),
        .clear    (clear),
        .en       (en && (state_q == COUNT)),
        .in_bit   (in_bit),
        .cnt      (cnt_unused),
        .run_done (run_done)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = out_bit;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (clear) begin
            state_d = COUNT;
        end else if (en) begin
            case (state_q)
                COUNT: begin
                    bit_d   = in_bit;
                    valid_d = 1'b1;
                    if (run_done) state_d = STRIP;
                end
                STRIP: begin
`ifdef USB_UNSTUFF_ERR_EN
                    if (in_bit) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = COUNT;
                    end
`else
                    // Lenient: a one in the stuff slot is dropped like the zero.
                    state_d = COUNT;
`endif
                end
`ifdef USB_UNSTUFF_ERR_EN
                ERR:     state_d = ERR;
`endif
                default: state_d = COUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q   <= COUNT;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            stuff_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_bit   <= bit_d;
            out_valid <= valid_d;
            stuff_err <= err_d;
        end
    end

endmodule

// File: tb/tb_usb_bit_unstuffer.sv
// Directed bench for usb_bit_unstuffer (RUN_LEN=6); honours USB_UNSTUFF_ERR_EN.
module tb_usb_bit_unstuffer;

    logic clk = 1'b0;
    logic nRST, in_bit, en, clear;
    logic out_bit, out_valid, stuff_err;
    int   n_tests = 0;
    int   n_fail  = 0;

    usb_bit_unstuffer #(.RUN_LEN(6)) dut (
        .clk       (clk),
        .nRST      (nRST),
        .in_bit    (in_bit),
        .en        (en),
        .clear     (clear),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .stuff_err (stuff_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle, then check the registered result 1 time unit after the edge.
    task automatic step(input string tag, input logic e, input logic c, input logic b,
                        input logic ev, input logic eb, input logic ee);
        en = e; clear = c; in_bit = b;
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, out_valid, ev);
        if (ev) chk({tag, ".bit"}, out_bit, eb);
        chk({tag, ".err"}, stuff_err, ee);
    endtask

    initial begin
        nRST = 1'b0; en = 1'b0; clear = 1'b0; in_bit = 1'b0;
        #12;
        chk("rst.valid", out_valid, 1'b0);
        chk("rst.bit", out_bit, 1'b0);
        chk("rst.err", stuff_err, 1'b0);
        @(negedge clk);
        nRST = 1'b1;

        // 1: reset mid-run restarts the count
        for (int i = 0; i < 3; i++) step("t1.pre", 1, 0, 1, 1, 1, 0);
        en = 1'b0;
        #2 nRST = 1'b0;
        #1;
        chk("t1.async.valid", out_valid, 1'b0);
        chk("t1.async.err", stuff_err, 1'b0);
        chk("t1.async.bit", out_bit, 1'b0);
        #2 nRST = 1'b1;
        for (int i = 0; i < 6; i++) step("t1.ones", 1, 0, 1, 1, 1, 0);
        step("t1.strip0", 1, 0, 0, 0, 0, 0);

        // 2: 1111110 1
        for (int i = 0; i < 6; i++) step("t2.ones", 1, 0, 1, 1, 1, 0);
        step("t2.strip", 1, 0, 0, 0, 0, 0);
        step("t2.after", 1, 0, 1, 1, 1, 0);
        step("t2.clr", 1, 1, 1, 0, 0, 0);

        // 3/4: violation 1111111, then 0
        for (int i = 0; i < 6; i++) step("t3.ones", 1, 0, 1, 1, 1, 0);
`ifdef USB_UNSTUFF_ERR_EN
        step("t3.viol", 1, 0, 1, 0, 0, 1);
        step("t3.err1", 1, 0, 1, 0, 0, 0);
        step("t3.err0", 1, 0, 0, 0, 0, 0);
        step("t3.gap", 0, 0, 0, 0, 0, 0);
        step("t3.err0b", 1, 0, 0, 0, 0, 0);
        step("t3.clr", 0, 1, 0, 0, 0, 0);
        step("t3.a", 1, 0, 1, 1, 1, 0);
        step("t3.b", 1, 0, 0, 1, 0, 0);
`else
        step("t4.viol", 1, 0, 1, 0, 0, 0);
        step("t4.zero", 1, 0, 0, 1, 0, 0);
        step("t4.one", 1, 0, 1, 1, 1, 0);
`endif
        step("t34.clr", 0, 1, 0, 0, 0, 0);

        // 5: en gaps inside a run and inside the strip slot
        for (int i = 0; i < 3; i++) step("t5.g1", 1, 0, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step("t5.gap1", 0, 0, 0, 0, 0, 0);
            chk("t5.gap1.hold", out_bit, 1'b1);
        end
        step("t5.g2", 1, 0, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) step("t5.gap2", 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) step("t5.g3", 1, 0, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) step("t5.gap3", 0, 0, 1, 0, 0, 0);
        step("t5.strip", 1, 0, 0, 0, 0, 0);
        step("t5.next0", 1, 0, 0, 1, 0, 0);

        // 6: clear after 4 ones restarts the count; in_bit ignored during clear
        for (int i = 0; i < 4; i++) step("t6.pre", 1, 0, 1, 1, 1, 0);
        step("t6.clr", 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) step("t6.ones", 1, 0, 1, 1, 1, 0);
        step("t6.zero", 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step("t6.pre2", 1, 0, 1, 1, 1, 0);
        step("t6.clr2", 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step("t6.run", 1, 0, 1, 1, 1, 0);
        step("t6.strip", 1, 0, 0, 0, 0, 0);
        step("t6.tail", 1, 0, 0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
